serial_comp_driver: RTL and testbench



---
 rtl/serial_comp_driver.sv | 125 ++++++++++++
 tb/tb_serial_comp_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_comp_driver.sv
// serial_comp_driver: loads two WIDTH-bit operands, clears the serial comparator, shifts the
// operands into it one bit per clock and holds the captured L/E/G result behind a valid/ready
// handshake. Default ordering is LSB first; define SC_MSB_FIRST_EN for MSB-first shifting.
module serial_comp_driver #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    output logic             sc_reset,
    output logic             sc_a,
    output logic             sc_b,
    input  logic             sc_l,
    input  logic             sc_e,
    input  logic             sc_g,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_lt,
    output logic             res_eq,
    output logic             res_gt,
    output logic             res_err
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

`ifdef SC_MSB_FIRST_EN
    localparam int TAP = WIDTH - 1;
`else
    localparam int TAP = 0;
`endif

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, WAIT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sra, srb;
    logic [CW-1:0]    count;
    logic             clr_pulse, load, shift_en, capture;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        clr_pulse  = 1'b0;
        load       = 1'b0;
        shift_en   = 1'b0;
        capture    = 1'b0;
        sc_a       = 1'b0;
        sc_b       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = CLR;
                end
            end
            CLR: begin
                clr_pulse  = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                sc_a     = sra[TAP];
                sc_b     = srb[TAP];
                if (count + CW'(1) == LAST) state_next = WAIT;
            end
            WAIT: begin
                capture    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The comparator clears together with this block as well as on the CLR pulse.
    assign sc_reset = reset | clr_pulse;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sra     <= '0;
            srb     <= '0;
            count   <= '0;
            res_lt  <= 1'b0;
            res_eq  <= 1'b0;
            res_gt  <= 1'b0;
            res_err <= 1'b0;
        end else begin
            if (load) begin
                sra <= a_word;
                srb <= b_word;
            end else if (shift_en) begin
`ifdef SC_MSB_FIRST_EN
                sra <= sra << 1;
                srb <= srb << 1;
`else
                sra <= sra >> 1;
                srb <= srb >> 1;
`endif
                count <= count + CW'(1);
            end
            if (clr_pulse) count <= '0;
            if (capture) begin
                res_lt  <= sc_l;
                res_eq  <= sc_e;
                res_gt  <= sc_g;
                res_err <= !$onehot({sc_l, sc_e, sc_g});
            end
        end
    end

endmodule

// File: tb/tb_serial_comp_driver.sv
// Directed bench for serial_comp_driver with a behavioural bit-serial comparator attached,
// plus a WIDTH=1 instance with a constant comparator response.
module tb_serial_comp_driver;
    localparam int W = 4;

`ifdef SC_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid, res_ready;
    logic [W-1:0] a_word, b_word;
    logic         in_ready, sc_reset, sc_a, sc_b, sc_l, sc_e, sc_g;
    logic         res_valid, res_lt, res_eq, res_gt, res_err;

    // Behavioural comparator: cleared by sc_reset, registered L/E/G, optional override.
    logic m_l, m_e, m_g;
    logic force_en = 1'b0, force_l = 1'b0, force_e = 1'b0, force_g = 1'b0;

    always @(posedge clock or posedge sc_reset) begin
        if (sc_reset) begin
            {m_l, m_e, m_g} <= 3'b010;
        end else if (sc_a != sc_b && (!MSB_FIRST || m_e)) begin
            {m_l, m_e, m_g} <= {sc_b, 1'b0, sc_a};
        end
    end

    assign sc_l = force_en ? force_l : m_l;
    assign sc_e = force_en ? force_e : m_e;
    assign sc_g = force_en ? force_g : m_g;

    serial_comp_driver #(.WIDTH(W)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_word(a_word), .b_word(b_word),
        .sc_reset(sc_reset), .sc_a(sc_a), .sc_b(sc_b),
        .sc_l(sc_l), .sc_e(sc_e), .sc_g(sc_g),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt), .res_err(res_err)
    );

    logic in_valid1, res_ready1;
    logic [0:0] a1, b1;
    logic in_ready1, sc_reset1, sc_a1, sc_b1, res_valid1, res_lt1, res_eq1, res_gt1, res_err1;

    serial_comp_driver #(.WIDTH(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a_word(a1), .b_word(b1),
        .sc_reset(sc_reset1), .sc_a(sc_a1), .sc_b(sc_b1),
        .sc_l(1'b0), .sc_e(1'b0), .sc_g(1'b1),
        .res_valid(res_valid1), .res_ready(res_ready1),
        .res_lt(res_lt1), .res_eq(res_eq1), .res_gt(res_gt1), .res_err(res_err1)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one transaction starting at the current negedge and follow it to the held result.
    // exp = {err, lt, eq, gt}
    task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] exp);
        int idx;
        in_valid = 1'b1;
        a_word   = a;
        b_word   = b;
        @(negedge clock);                       // cycle 1
        in_valid = 1'b0;
        check("clr_sc_reset", sc_reset, 1);
        check("clr_in_ready", in_ready, 0);
        for (int i = 0; i < W; i++) begin
            @(negedge clock);                   // cycle 2+i
            idx = MSB_FIRST ? (W - 1 - i) : i;
            check($sformatf("sc_a_bit%0d", i), sc_a, a[idx]);
            check($sformatf("sc_b_bit%0d", i), sc_b, b[idx]);
            check("shift_sc_reset", sc_reset, 0);
        end
        @(negedge clock);                       // cycle W+2
        check("wait_res_valid", res_valid, 0);
        check("wait_sc_a", sc_a, 0);
        @(negedge clock);                       // cycle W+3
        check("done_res_valid", res_valid, 1);
        check("done_in_ready", in_ready, 0);
        check("res_err", res_err, exp[3]);
        check("res_lt", res_lt, exp[2]);
        check("res_eq", res_eq, exp[1]);
        check("res_gt", res_gt, exp[0]);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        check("consumed_res_valid", res_valid, 0);
        check("consumed_in_ready", in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        res_ready  = 1'b0;
        a_word     = '0;
        b_word     = '0;
        in_valid1  = 1'b0;
        res_ready1 = 1'b0;
        a1         = '0;
        b1         = '0;

        // Reset and idle
        @(negedge clock);
        check("rst_sc_reset", sc_reset, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("idle_in_ready", in_ready, 1);
            check("idle_res_valid", res_valid, 0);
            check("idle_res", {res_err, res_lt, res_eq, res_gt}, 4'b0000);
            check("idle_sc_ab", {sc_a, sc_b}, 2'b00);
            check("idle_sc_reset", sc_reset, 0);
        end

        // A=1010, B=0110 -> greater
        do_txn(4'b1010, 4'b0110, 4'b0001);
        consume();
        check("retained_gt", res_gt, 1);

        // Back to back: F/F equal, then 3/8 less
        do_txn(4'hF, 4'hF, 4'b0010);
        consume();
        do_txn(4'h3, 4'h8, 4'b0100);

        // Hold result while new operands are offered
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0);
            a_word   = 4'h1;
            b_word   = 4'h2;
            @(negedge clock);
            check("hold_res_valid", res_valid, 1);
            check("hold_res", {res_err, res_lt, res_eq, res_gt}, 4'b0100);
            check("hold_in_ready", in_ready, 0);
            check("hold_sc_reset", sc_reset, 0);
        end
        in_valid = 1'b0;
        consume();
        @(negedge clock);
        check("no_accept_sc_reset", sc_reset, 0);
        check("no_accept_in_ready", in_ready, 1);
        check("retained_lt", res_lt, 1);

        // Reset during the third SHIFT cycle
        in_valid = 1'b1;
        a_word   = 4'hF;
        b_word   = 4'h0;
        @(negedge clock);                       // cycle 1
        in_valid = 1'b0;
        @(negedge clock);                       // cycle 2
        @(negedge clock);                       // cycle 3
        @(negedge clock);                       // cycle 4 (third SHIFT cycle)
        check("pre_rst_sc_a", sc_a, 1);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_sc_ab", {sc_a, sc_b}, 2'b00);
        check("midrst_sc_reset", sc_reset, 1);
        check("midrst_res", {res_err, res_lt, res_eq, res_gt}, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_res_valid", res_valid, 0);
        do_txn(4'h9, 4'h9, 4'b0010);
        consume();

        // Comparator forced to L=1, E=1 -> error flagged
        force_en = 1'b1;
        force_l  = 1'b1;
        force_e  = 1'b1;
        force_g  = 1'b0;
        do_txn(4'h2, 4'h1, 4'b1110);
        force_en = 1'b0;
        consume();

        // WIDTH=1 instance: one SHIFT cycle, result from cycle 4
        in_valid1 = 1'b1;
        a1        = 1'b1;
        b1        = 1'b0;
        @(negedge clock);                       // cycle 1
        in_valid1 = 1'b0;
        check("w1_sc_reset", sc_reset1, 1);
        @(negedge clock);                       // cycle 2
        check("w1_sc_ab", {sc_a1, sc_b1}, 2'b10);
        @(negedge clock);                       // cycle 3
        check("w1_wait_res_valid", res_valid1, 0);
        check("w1_wait_sc_a", sc_a1, 0);
        @(negedge clock);                       // cycle 4
        check("w1_res_valid", res_valid1, 1);
        check("w1_res", {res_err1, res_lt1, res_eq1, res_gt1}, 4'b0001);
        res_ready1 = 1'b1;
        @(negedge clock);
        res_ready1 = 1'b0;
        check("w1_in_ready", in_ready1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
